// File: rtl/cache_mem_arbiter.sv
// Shares the single main-memory port between I-cache fills, D-cache fills and
// D-cache write-through stores; fills stream 8 word reads and steer returns.
module cache_mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_write,
  input  logic [15:0] d_write_addr,
  input  logic [15:0] d_write_data,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [3:0]  fill_offset,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_write_ack,
  output logic        i_busy,
  output logic        d_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_t;

  localparam logic [3:0] ISSUE_MAX = 4'(BLOCK_WORDS);
  localparam logic [2:0] RECV_LAST = 3'(BLOCK_WORDS - 1);

  state_t      state_r, state_s;
  logic [3:0]  issue_cnt_r, issue_cnt_s;
  logic [2:0]  recv_cnt_r, recv_cnt_s;
  logic        last_fill_r, last_fill_s;
  logic [15:0] base_r, base_s;
  logic [15:0] wr_addr_r, wr_addr_s;
  logic [15:0] wr_data_r, wr_data_s;
  logic        issuing_s;
  logic        last_word_s;
  logic        filling_s;

  assign filling_s   = (state_r == FILL_I) || (state_r == FILL_D);
  assign issuing_s   = (issue_cnt_r != ISSUE_MAX);
  assign last_word_s = (recv_cnt_r == RECV_LAST);

  // State, counters and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      issue_cnt_r <= 4'd0;
      recv_cnt_r  <= 3'd0;
      last_fill_r <= 1'b0;
      base_r      <= 16'h0000;
      wr_addr_r   <= 16'h0000;
      wr_data_r   <= 16'h0000;
    end else begin
      state_r     <= state_s;
      issue_cnt_r <= issue_cnt_s;
      recv_cnt_r  <= recv_cnt_s;
      last_fill_r <= last_fill_s;
      base_r      <= base_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
    end
  end

  // Next-state: store priority, round-robin between fills, fill sequencing.
  always_comb begin
    state_s     = state_r;
    issue_cnt_s = issue_cnt_r;
    recv_cnt_s  = recv_cnt_r;
    last_fill_s = last_fill_r;
    base_s      = base_r;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    case (state_r)
      IDLE: begin
        issue_cnt_s = 4'd0;
        recv_cnt_s  = 3'd0;
        if (d_write) begin
          state_s   = WRITE;
          wr_addr_s = d_write_addr;
          wr_data_s = d_write_data;
        end else if (i_miss && (!d_miss || last_fill_r)) begin
          // I wins alone, or on a tie when D was served last.
          state_s     = FILL_I;
          base_s      = i_miss_addr & 16'hFFF0;
          last_fill_s = 1'b0;
        end else if (d_miss) begin
          state_s     = FILL_D;
          base_s      = d_miss_addr & 16'hFFF0;
          last_fill_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s = IDLE;
      end
      FILL_I, FILL_D: begin
        if (issuing_s) begin
          issue_cnt_s = issue_cnt_r + 4'd1;
        end else begin
          issue_cnt_s = issue_cnt_r;
        end
        if (mem_data_valid) begin
          recv_cnt_s = recv_cnt_r + 3'd1;
          if (last_word_s) begin
            state_s = IDLE;
          end else begin
            state_s = state_r;
          end
        end else begin
          recv_cnt_s = recv_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Memory port and cache steering, combinational from state and counters.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_data_in  = 16'h0000;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    fill_offset  = 4'd0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_write_ack  = 1'b0;
    case (state_r)
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr_r;
        mem_data_in = wr_data_r;
        d_write_ack = 1'b1;
      end
      FILL_I, FILL_D: begin
        fill_offset = {recv_cnt_r, 1'b0};
        if (issuing_s) begin
          mem_en   = 1'b1;
          mem_addr = base_r | {12'h000, issue_cnt_r[2:0], 1'b0};
        end else begin
          mem_en = 1'b0;
        end
        if (mem_data_valid && (state_r == FILL_I)) begin
          i_data_valid = 1'b1;
          i_fill_done  = last_word_s;
        end else if (mem_data_valid) begin
          d_data_valid = 1'b1;
          d_fill_done  = last_word_s;
        end else begin
          i_data_valid = 1'b0;
        end
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  assign i_busy = (state_r == FILL_I) || i_miss;
  assign d_busy = (state_r == FILL_D) || (state_r == WRITE) || d_miss || d_write;

  cache_mem_arbiter_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .filling      (filling_s),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .i_data_valid (i_data_valid),
    .d_data_valid (d_data_valid),
    .i_fill_done  (i_fill_done),
    .d_fill_done  (d_fill_done),
    .d_write_ack  (d_write_ack)
  );

endmodule

// Protocol invariants of the arbiter outputs.
module cache_mem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic filling,
  input logic mem_en,
  input logic mem_wr,
  input logic i_data_valid,
  input logic d_data_valid,
  input logic i_fill_done,
  input logic d_fill_done,
  input logic d_write_ack
);
  a_wr_en:    assert property (@(posedge clk) disable iff (rst) mem_wr |-> mem_en);
  a_one_dv:   assert property (@(posedge clk) disable iff (rst) !(i_data_valid && d_data_valid));
  a_i_done:   assert property (@(posedge clk) disable iff (rst) i_fill_done |-> i_data_valid);
  a_d_done:   assert property (@(posedge clk) disable iff (rst) d_fill_done |-> d_data_valid);
  a_ack_wr:   assert property (@(posedge clk) disable iff (rst) d_write_ack |-> mem_wr);
  a_dv_fill:  assert property (@(posedge clk) disable iff (rst) (i_data_valid || d_data_valid) |-> filling);
endmodule
